traffic_light_param_ctrl: RTL and testbench

TRAFFIC_LIGHT_PARAM_CTRL -- requirements
Module: traffic_light_param_ctrl

---
 rtl/traffic_light_param_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_traffic_light_param_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_param_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_param_ctrl
//
// Two-road intersection controller with pedestrian phase and night flash.
// Road A is the main road and rests in green. Side-road vehicles (i_car_b) and
// pedestrian presses (i_ped_req) are latched as pending requests that pull the
// controller out of A_GREEN once its minimum green time has elapsed.
//
// Ports:
//   i_clk      - clock, all logic on the rising edge
//   i_rst      - synchronous active-high reset
//   i_car_b    - side-road (B) vehicle sensor level
//   i_ped_req  - pedestrian push button, sampled every cycle
//   i_night    - night-mode request level (flashing yellow on both roads)
//   o_light    - [5:3] road A {R,Y,G}, [2:0] road B {R,Y,G}
//   o_walk     - pedestrian walk lamp
//   o_ped_ack  - one-cycle pulse when a button press has been latched
// -----------------------------------------------------------------------------
module traffic_light_param_ctrl #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int PED_CYC    = 5,
  parameter int FLASH_CYC  = 4,
  parameter int CNT_W      = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_car_b,
  input  logic       i_ped_req,
  input  logic       i_night,
  output logic [5:0] o_light,
  output logic       o_walk,
  output logic       o_ped_ack
);

  typedef enum logic [2:0] {
    S_A_GREEN  = 3'd0,
    S_A_YELLOW = 3'd1,
    S_ALLRED_AB = 3'd2,
    S_PED_WALK = 3'd3,
    S_B_GREEN  = 3'd4,
    S_B_YELLOW = 3'd5,
    S_ALLRED_BA = 3'd6,
    S_FLASH    = 3'd7
  } state_t;

  // Timer values on the last cycle of each timed state.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             flash_on_q, flash_on_d;
  logic             car_pend_q, car_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_ack_q, ped_ack_d;
  logic [5:0]       light_q, light_d;
  logic             walk_q, walk_d;
  logic             ped_set_s;
  logic             entry_s;

  // Lamp pattern for a state; FLASH alternates yellow-on-both with dark.
  function automatic logic [5:0] light_of(input state_t s, input logic on);
    logic [5:0] l;
    case (s)
      S_A_GREEN:   l = 6'b001_100;
      S_A_YELLOW:  l = 6'b010_100;
      S_B_GREEN:   l = 6'b100_001;
      S_B_YELLOW:  l = 6'b100_010;
      S_FLASH:     l = on ? 6'b010_010 : 6'b000_000;
      default:     l = 6'b100_100;
    endcase
    return l;
  endfunction

  // Next-state and flash-phase selection; night mode overrides every timer.
  always_comb begin
    state_d    = state_q;
    flash_on_d = flash_on_q;
    if (i_night) begin
      state_d = S_FLASH;
      if (state_q != S_FLASH) begin
        flash_on_d = 1'b1;
      end else if (timer_q == FLASH_LAST) begin
        flash_on_d = ~flash_on_q;
      end else begin
        flash_on_d = flash_on_q;
      end
    end else begin
      case (state_q)
        S_A_GREEN: begin
          // Main road holds green until a request arrives after the minimum.
          if ((timer_q == GREEN_LAST) && (car_pend_q || ped_pend_q)) begin
            state_d = S_A_YELLOW;
          end else begin
            state_d = S_A_GREEN;
          end
        end
        S_A_YELLOW: begin
          if (timer_q == YELLOW_LAST) state_d = S_ALLRED_AB;
          else                        state_d = S_A_YELLOW;
        end
        S_ALLRED_AB: begin
          if (timer_q == ALLRED_LAST) state_d = ped_pend_q ? S_PED_WALK : S_B_GREEN;
          else                        state_d = S_ALLRED_AB;
        end
        S_PED_WALK: begin
          if (timer_q == PED_LAST) state_d = car_pend_q ? S_B_GREEN : S_ALLRED_BA;
          else                     state_d = S_PED_WALK;
        end
        S_B_GREEN: begin
          if (timer_q == GREEN_LAST) state_d = S_B_YELLOW;
          else                       state_d = S_B_GREEN;
        end
        S_B_YELLOW: begin
          if (timer_q == YELLOW_LAST) state_d = S_ALLRED_BA;
          else                        state_d = S_B_YELLOW;
        end
        S_ALLRED_BA: begin
          if (timer_q == ALLRED_LAST) state_d = S_A_GREEN;
          else                        state_d = S_ALLRED_BA;
        end
        S_FLASH: begin
          state_d = S_ALLRED_BA;
        end
        default: begin
          state_d = S_A_GREEN;
        end
      endcase
    end
  end

  assign entry_s = (state_d != state_q);

  // State timer: cleared on entry and at each flash half-period; saturates in
  // A_GREEN once the minimum green is reached so it can never wrap.
  always_comb begin
    timer_d = timer_q + CNT_W'(1);
    if (entry_s) begin
      timer_d = {CNT_W{1'b0}};
    end else if ((state_q == S_FLASH) && (timer_q == FLASH_LAST)) begin
      timer_d = {CNT_W{1'b0}};
    end else if ((state_q == S_A_GREEN) && (timer_q == GREEN_LAST)) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  // Pending-request latches and the press acknowledge.
  always_comb begin
    ped_set_s  = i_ped_req && !ped_pend_q &&
                 (state_q != S_PED_WALK) && (state_q != S_FLASH);
    car_pend_d = car_pend_q;
    ped_pend_d = ped_pend_q;
    ped_ack_d  = 1'b0;
    if (i_night) begin
      car_pend_d = 1'b0;
    end else if (entry_s && (state_d == S_B_GREEN)) begin
      car_pend_d = 1'b0;
    end else if (i_car_b && (state_q != S_B_GREEN)) begin
      car_pend_d = 1'b1;
    end else begin
      car_pend_d = car_pend_q;
    end
    if (i_night) begin
      ped_pend_d = 1'b0;
      ped_ack_d  = 1'b0;
    end else if (entry_s && (state_d == S_PED_WALK)) begin
      // Entering PED_WALK requires ped_pend_q=1, so no press can be lost here.
      ped_pend_d = 1'b0;
      ped_ack_d  = 1'b0;
    end else if (ped_set_s) begin
      ped_pend_d = 1'b1;
      ped_ack_d  = 1'b1;
    end else begin
      ped_pend_d = ped_pend_q;
      ped_ack_d  = 1'b0;
    end
  end

  // Output decode from the next state so the lamps are registered yet still
  // track the current state in the same cycle.
  always_comb begin
    light_d = light_of(state_d, flash_on_d);
    walk_d  = (state_d == S_PED_WALK);
  end

  // State, timer, request and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_A_GREEN;
      timer_q    <= {CNT_W{1'b0}};
      flash_on_q <= 1'b1;
      car_pend_q <= 1'b0;
      ped_pend_q <= 1'b0;
      ped_ack_q  <= 1'b0;
      light_q    <= 6'b001_100;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      flash_on_q <= flash_on_d;
      car_pend_q <= car_pend_d;
      ped_pend_q <= ped_pend_d;
      ped_ack_q  <= ped_ack_d;
      light_q    <= light_d;
      walk_q     <= walk_d;
    end
  end

  assign o_light   = light_q;
  assign o_walk    = walk_q;
  assign o_ped_ack = ped_ack_q;

endmodule

// File: tb/tb_traffic_light_param_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for traffic_light_param_ctrl (default parameters).
// Directed scenarios followed by a randomized run; every cycle the outputs are
// compared with a phase/age reference model of the intersection.
// -----------------------------------------------------------------------------
module tb_traffic_light_param_ctrl;

  localparam int GREEN = 8;
  localparam int YEL   = 3;
  localparam int AR    = 2;
  localparam int PED   = 5;
  localparam int FLH   = 4;

  // Model phase identifiers
  localparam int AG = 0, AY = 1, ARAB = 2, PW = 3, BG = 4, BY = 5, ARBA = 6, FLS = 7;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_car_b = 1'b0;
  logic       i_ped_req = 1'b0;
  logic       i_night = 1'b0;
  logic [5:0] o_light;
  logic       o_walk;
  logic       o_ped_ack;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase, cycles spent in it (1 = first cycle).
  int m_st   = AG;
  int m_age  = 1;
  int m_fage = 1;
  bit m_car  = 1'b0;
  bit m_ped  = 1'b0;
  bit m_on   = 1'b1;
  bit m_ack  = 1'b0;

  // Observed-output tallies for scenario-level checks
  int c_walk, c_ack, c_bg, c_fon, c_foff;

  traffic_light_param_ctrl dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_car_b   (i_car_b),
    .i_ped_req (i_ped_req),
    .i_night   (i_night),
    .o_light   (o_light),
    .o_walk    (o_walk),
    .o_ped_ack (o_ped_ack)
  );

  always #5 i_clk = ~i_clk;

  function automatic int dur_of(input int s);
    case (s)
      AG, BG:    return GREEN;
      AY, BY:    return YEL;
      ARAB, ARBA: return AR;
      PW:        return PED;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [5:0] lamp_of(input int s, input bit on);
    logic [5:0] tbl [0:7];
    tbl[AG] = 6'b001100; tbl[AY] = 6'b010100; tbl[ARAB] = 6'b100100;
    tbl[PW] = 6'b100100; tbl[BG] = 6'b100001; tbl[BY] = 6'b100010;
    tbl[ARBA] = 6'b100100; tbl[FLS] = on ? 6'b010010 : 6'b000000;
    return tbl[s];
  endfunction

  // Advance the model by one clock edge with the inputs applied before it.
  task automatic model_step(input bit car, input bit ped, input bit night, input bit rst);
    int nst;
    bit car_n, ped_n, pset;
    if (rst) begin
      m_st = AG; m_age = 1; m_fage = 1; m_car = 0; m_ped = 0; m_on = 1; m_ack = 0;
    end else begin
      pset  = ped && !m_ped && (m_st != PW) && (m_st != FLS);
      car_n = m_car || (car && (m_st != BG));
      ped_n = m_ped || pset;
      m_ack = pset;
      nst   = m_st;
      if (night) begin
        nst = FLS; car_n = 0; ped_n = 0; m_ack = 0;
        if (m_st != FLS) begin
          m_on = 1; m_fage = 1;
        end else if (m_fage == FLH) begin
          m_on = !m_on; m_fage = 1;
        end else begin
          m_fage++;
        end
      end else begin
        case (m_st)
          AG:   nst = (m_age >= GREEN && (m_car || m_ped)) ? AY : AG;
          AY:   nst = (m_age == dur_of(AY)) ? ARAB : AY;
          ARAB: nst = (m_age == dur_of(ARAB)) ? (m_ped ? PW : BG) : ARAB;
          PW:   nst = (m_age == dur_of(PW)) ? (m_car ? BG : ARBA) : PW;
          BG:   nst = (m_age == dur_of(BG)) ? BY : BG;
          BY:   nst = (m_age == dur_of(BY)) ? ARBA : BY;
          ARBA: nst = (m_age == dur_of(ARBA)) ? AG : ARBA;
          FLS:  nst = ARBA;
          default: nst = AG;
        endcase
      end
      if (nst != m_st) begin
        m_age = 1;
        if (nst == BG) car_n = 0;
        if (nst == PW) ped_n = 0;
      end else begin
        m_age++;
      end
      m_st = nst; m_car = car_n; m_ped = ped_n;
    end
  endtask

  task automatic check_outputs();
    logic [5:0] el;
    el = lamp_of(m_st, m_on);
    checks++;
    assert (o_light === el) else begin
      errors++;
      $error("FAIL light: observed %b expected %b at %0t", o_light, el, $time);
    end
    checks++;
    assert (o_walk === (m_st == PW)) else begin
      errors++;
      $error("FAIL walk: observed %b expected %b at %0t", o_walk, (m_st == PW), $time);
    end
    checks++;
    assert (o_ped_ack === m_ack) else begin
      errors++;
      $error("FAIL ack: observed %b expected %b at %0t", o_ped_ack, m_ack, $time);
    end
    if (o_walk === 1'b1) c_walk++;
    if (o_ped_ack === 1'b1) c_ack++;
    if (o_light === 6'b100001) c_bg++;
    if (o_light === 6'b010010) c_fon++;
    if (o_light === 6'b000000) c_foff++;
  endtask

  task automatic check_count(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, step model at the edge, compare 1 time unit later.
  task automatic cycle(input bit car, input bit ped, input bit night, input bit rst);
    i_car_b = car; i_ped_req = ped; i_night = night; i_rst = rst;
    @(posedge i_clk);
    model_step(car, ped, night, rst);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_tallies();
    c_walk = 0; c_ack = 0; c_bg = 0; c_fon = 0; c_foff = 0;
  endtask

  initial begin : stim
    bit nt;

    // Reset then long idle: main road keeps green
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_count("reset_light", int'(o_light), int'(6'b001100));
    clear_tallies();
    idle(200);
    check_count("idle_walk", c_walk, 0);
    check_count("idle_ack", c_ack, 0);
    check_count("idle_bgreen", c_bg, 0);

    // Single car pulse at reset+2
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    clear_tallies();
    idle(2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(45);
    check_count("car_bgreen_cycles", c_bg, 8);
    check_count("car_walk_cycles", c_walk, 0);
    check_count("car_end_light", int'(o_light), int'(6'b001100));

    // Pedestrian press at reset+20, ack at reset+21
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    clear_tallies();
    idle(20);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_count("ped_ack_time", int'(o_ped_ack), 1);
    idle(30);
    check_count("ped_ack_count", c_ack, 1);
    check_count("ped_walk_cycles", c_walk, 5);
    check_count("ped_bgreen_cycles", c_bg, 0);

    // Simultaneous car + ped, repeat press while pending
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    clear_tallies();
    idle(10);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(40);
    check_count("both_ack_count", c_ack, 1);
    check_count("both_walk_cycles", c_walk, 5);
    check_count("both_bgreen_cycles", c_bg, 8);

    // Night mode during B_GREEN for 20 cycles
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(13);
    check_count("night_pre_bgreen", int'(o_light), int'(6'b100001));
    clear_tallies();
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_count("flash_on_cycles", c_fon, 12);
    check_count("flash_off_cycles", c_foff, 8);
    idle(10);
    check_count("night_end_light", int'(o_light), int'(6'b001100));

    // Reset during PED_WALK with a car pending
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(13);
    check_count("rst_pre_walk", int'(o_walk), 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_count("rst_light", int'(o_light), int'(6'b001100));
    check_count("rst_walk", int'(o_walk), 0);
    clear_tallies();
    idle(30);
    check_count("rst_hold_bgreen", c_bg, 0);
    check_count("rst_hold_walk", c_walk, 0);

    // Randomized traffic with occasional night periods and resets
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    nt = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 59) == 0) nt = !nt;
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, nt,
            $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
